btn_event_arbiter: RTL
======================

# btn_event_arbiter

Front-end controller for the push-button path. It takes N raw asynchronous button levels and, per button, runs a two-flop synchronizer, a debounce counter and a press single-pulser. Each resulting press is latched as pending. A round-robin arbiter then shares one valid/ready event channel between all buttons, so downstream logic sees one button press at a time, identified by index.

## Interface
- `N_BTN`, default 4: number of buttons, ≥2.
- `DEB_CYCLES`, default 16: consecutive synchronized samples a new level must hold before it is accepted, ≥2.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `press_i`  in  N_BTN: raw button levels, active-high, asynchronous to `clk`.
- `stable_o`  out  N_BTN: debounced button levels.
- `pending_o`  out  N_BTN: per-button latched press not yet delivered.
- `evt_valid_o`  out  1: an event is offered on the channel.
- `evt_id_o`  out  $clog2(N_BTN): index of the offered button.
- `evt_ready_i`  in  1: consumer accepts the event.
- `overflow_o`  out  1: one-cycle pulse when a press is dropped.

## Operation
- Reset (`rst`=0, immediate) clears the following to 0:
  - sync flops, debounce counters, `stable_o`, `pending_o`, `evt_valid_o`, `evt_id_o`, `overflow_o`;
  - the arbiter FSM, to IDLE;
  - round-robin pointer `last`, to N_BTN-1, so button 0 has first priority.
- Per button:
  - `s` is the second synchronizer flop.
  - Counter rule: if `s`==`stable`, the counter is 0. Otherwise the counter increments. When `s`≠`stable` and counter==DEB_CYCLES-1, set `stable`<=`s` and counter<=0.
  - A `stable` 0→1 update is a press event (`rise`). 1→0 updates produce no event.
- Pending: on `rise`, `pending[i]` is set at the same edge as the `stable` update.
  - If `pending[i]` is already 1 and not being cleared that edge: the press is dropped, and `overflow_o`=1 for the next cycle.
  - Set and clear on the same edge: set wins, and `pending[i]` stays 1.
- Arbiter FSM:
  - IDLE: if `pending`≠0, choose the first set bit searching from `last`+1 upward and wrapping modulo N_BTN. Register it into `evt_id_o`, set `evt_valid_o`=1, and go to OFFER.
  - OFFER: `evt_id_o` and `evt_valid_o` are held stable until `evt_valid_o`&`evt_ready_i` at an edge. At that edge: clear `pending[evt_id_o]`, set `last`<=`evt_id_o`, set `evt_valid_o`<=0, and go to IDLE.
  - `evt_ready_i` while not valid is ignored.
- A button still held across reset release counts as a new press.

## Timing
- Press latency: a `press_i` level stable from before edge 1 gives `stable_o` and `pending_o` high after edge DEB_CYCLES+2. `evt_valid_o` follows one edge later when the FSM is in IDLE.
- Release latency is the same, DEB_CYCLES+2 edges, with no event.
- Bounce: any sample of `s` equal to `stable` resets the counter, so glitches shorter than DEB_CYCLES cycles are invisible.
- Throughput: at most one event per 2 cycles, because of the mandatory IDLE cycle after each handshake.
- Fairness: with all buttons pending continuously, each button is granted once per N_BTN events.
- All outputs are registered; there is no combinational path from `evt_ready_i` to any output.

## Structure
- Package `btn_pkg`:
  - FSM state enum {IDLE, OFFER};
  - default DEB_CYCLES constant;
  - `clog2`-derived width helper for counter and index.
- Sub-module `btn_debounce`, instantiated N_BTN times by generate:
  - contains the synchronizer, the counter (width $clog2(DEB_CYCLES)), the `stable` register and the `rise` output.
- The top level holds the pending vector, the overflow logic, the round-robin search, the FSM and the event registers.

## Test plan
Run with N_BTN=4 and DEB_CYCLES=4.
1. Assert `rst`=0 mid-clock with `press_i`=4'b1111 -> every output is 0 immediately and stays 0 until 6 edges after release; then `pending_o`=4'b1111.
2. Raise `press_i[1]` before edge 1, held, with `evt_ready_i`=1 ->
   - `pending_o[1]` high after edge 6;
   - `evt_valid_o`=1 with `evt_id_o`=1 after edge 7;
   - `pending_o[1]` cleared after edge 8;
   - exactly one event.
3. Toggle `press_i[0]` every 2 cycles for 12 cycles, then hold it high -> `stable_o[0]` stays 0 during the toggling and rises 6 edges after the hold starts; exactly one event, id 0.
4. Press buttons 0 and 2 together, with `evt_ready_i`=0 for 5 cycles ->
   - id 0 is held stable with valid high throughout;
   - after ready=1 the events are id 0, then id 2, each followed by an IDLE cycle.
   - Then press buttons 0 and 3 together -> id 3 is granted first.
5. With `evt_ready_i`=0: press button 3, release it for 6 cycles, press it again -> `overflow_o` pulses for exactly 1 cycle; only one id-3 event is delivered.
6. With button 2 held and the FSM in OFFER, pulse `rst` low -> `evt_valid_o` drops asynchronously; id 2 is re-offered 7 edges after `rst` release.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared types and helpers for the push-button front end.
//   arb_state_e      - event arbiter FSM states
//   DEB_CYCLES_DEF   - default debounce length in clock cycles
//   bits_for()       - register width needed to hold values 0..n-1 (min 1)
package btn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  localparam int DEB_CYCLES_DEF = 16;

  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button lane.
//   Two-flop synchronizer, debounce counter and a rising-edge detector on
//   the debounced level.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   raw    - raw button level, asynchronous to clk
//   stable - debounced level
//   rise   - high in the cycle whose edge moves stable from 0 to 1
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = bits_for(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          settle;

  // The sample at this edge is the DEB_CYCLES-th consecutive one that
  // disagrees with the accepted level, so the new level is taken now.
  assign settle = (s != stable) && (cnt == CNT_LAST);
  assign rise   = settle & s;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      if (s == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: push-button front end.
//   Per-button debounce lanes feed a pending-press vector; a round-robin
//   arbiter offers one pending press at a time on a valid/ready channel.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset
//   press_i      - raw button levels (N_BTN), asynchronous
//   stable_o     - debounced button levels
//   pending_o    - presses latched but not yet delivered
//   evt_valid_o  - an event is offered
//   evt_id_o     - index of the offered button
//   evt_ready_i  - consumer accepts the offered event
//   overflow_o   - one-cycle pulse when a press is dropped
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         press_i,
  output logic [N_BTN-1:0]         stable_o,
  output logic [N_BTN-1:0]         pending_o,
  output logic                     evt_valid_o,
  output logic [$clog2(N_BTN)-1:0] evt_id_o,
  input  logic                     evt_ready_i,
  output logic                     overflow_o
);

  localparam int IW = bits_for(N_BTN);

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] clear;
  logic [IW-1:0]    last;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    cand;
  logic             found;
  arb_state_e       state;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_lane
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (press_i[gi]),
      .stable (stable_o[gi]),
      .rise   (rise[gi])
    );
  end

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    clear = '0;
    if (evt_valid_o && evt_ready_i) clear[evt_id_o] = 1'b1;
  end

  // Round-robin search starting just after the last granted button. The loop
  // runs from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N_BTN);
      if (pending_o[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // A new press always lands in pending (set wins over a same-edge clear);
  // it is only dropped when the slot is still occupied after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      pending_o  <= (pending_o & ~clear) | rise;
      overflow_o <= |(rise & pending_o & ~clear);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      last        <= IW'(N_BTN - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            evt_id_o    <= pick;
            evt_valid_o <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready_i) begin
            last        <= evt_id_o;
            evt_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          evt_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
